seq_mult8: RTL and testbench

//  Sequential shift-and-add 8x8 unsigned multiplier; upstream driver and downstream consumer of adder8bit.

---
 rtl/seq_mult8.sv | 131 +++++++++++++
 tb/tb_seq_mult8.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult8.sv
// seq_mult8: sequential shift-and-add 8x8 unsigned multiplier built around adder8bit.
// Latency: start accepted at edge E0; product and done valid in the cycle after E8 (9-cycle throughput).
// Backpressure: none downstream; start is ignored while busy and accepted again in IDLE or DONE.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start, A, B      request and operands (A multiplicand, B multiplier), latched on acceptance
//   busy             high while the add/shift sequence runs
//   done, Product    one-cycle completion pulse and the 16-bit product, held until the next completion

// adder8bit: 8-bit ripple adder with carry in/out. Purely combinational.
module adder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module seq_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] m_q, m_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] q_q, q_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [15:0] product_q, product_d;

  logic [7:0] add_sum;
  logic       add_cout;
  logic [7:0] step_s;
  logic       step_c;
  logic [7:0] acc_next;
  logic [7:0] q_next;

  adder8bit u_adder (
    .a    (acc_q),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Add the multiplicand only when the current multiplier bit is set, then
  // shift the 17-bit {carry, sum, Q} right by one so the carry lands in ACC[7].
  always_comb begin
    step_c   = q_q[0] ? add_cout : 1'b0;
    step_s   = q_q[0] ? add_sum  : acc_q;
    acc_next = {step_c, step_s[7:1]};
    q_next   = {step_s[0], q_q[7:1]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          m_d     = A;
          q_d     = B;
          acc_d   = 8'd0;
          cnt_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_next;
        q_d   = q_next;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          product_d = {acc_next, q_next};
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= 8'd0;
      acc_q     <= 8'd0;
      q_q       <= 8'd0;
      cnt_q     <= 3'd0;
      done_q    <= 1'b0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign Product = product_q;

endmodule

// File: tb/tb_seq_mult8.sv
// tb_seq_mult8: scoreboard bench for seq_mult8.
// Expected products are queued when a start is driven and popped on each done pulse.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_seq_mult8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] Product;

  int tests_run;
  int tests_failed;
  int cyc;
  int done_seen;
  logic [15:0] exp_q[$];

  seq_mult8 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .Product (Product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Accept one operation: operands driven and expected product queued, then the accepting edge.
  task accept(input logic [7:0] a, input logic [7:0] b, input bit push);
    A     = a;
    B     = b;
    start = 1'b1;
    if (push) exp_q.push_back(16'(a) * 16'(b));
    tick();
    cyc = 0;
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then score the product against the queue head.
  task wait_done(input string tag);
    logic [15:0] exp;
    while (!done && cyc < 30) tick();
    check({tag, "_lat"}, cyc, 8);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_prod"}, Product, exp);
    end
    check({tag, "_busy_in_done"}, busy, 0);
  endtask

  task run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    accept(a, b, 1'b1);
    check({tag, "_busy"}, busy, 1);
    wait_done(tag);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rst_n = 1'b0;
    start = 1'b1;
    A     = 8'h55;
    B     = 8'h66;

    // T1: reset held with start asserted.
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", Product, 16'h0000);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_no_run", busy, 0);

    // T2..T4: basic, carry path, zero and identity.
    run_op("t2_0f_0f", 8'h0F, 8'h0F);
    run_op("t3_ff_ff", 8'hFF, 8'hFF);
    run_op("t3_80_02", 8'h80, 8'h02);
    run_op("t4_00_a5", 8'h00, 8'hA5);
    run_op("t4_37_01", 8'h37, 8'h01);
    run_op("rnd_c3_9b", 8'hC3, 8'h9B);

    // T5a: start pulsed mid-run is ignored.
    accept(8'h03, 8'h04, 1'b1);
    tick();
    tick();
    A     = 8'hFF;
    B     = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy_kept", busy, 1);
    wait_done("t5_ignore");
    tick();

    // T5b: reset mid-run aborts without a done pulse.
    accept(8'h03, 8'h04, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_prod", Product, 16'h0000);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("t5_abort_no_done", done_seen, 0);

    // T6: back-to-back with start held high.
    A     = 8'h12;
    B     = 8'h34;
    start = 1'b1;
    exp_q.push_back(16'h03A8);
    tick();
    cyc = 0;
    A = 8'hFE;
    B = 8'h03;
    exp_q.push_back(16'h02FA);
    check("t6_busy1", busy, 1);
    wait_done("t6_first");
    tick();
    cyc = 0;
    start = 1'b0;
    check("t6_busy2", busy, 1);
    wait_done("t6_second");
    tick();
    check("t6_idle", busy, 0);
    check("t6_sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
